// File: rtl/id_scanner_pkg.sv
// Shared definitions for the boot-time peripheral ID scanner: FSM encodings,
// default timeout and the select-port width helper.
package id_scanner_pkg;

    typedef enum logic [1:0] {
        ID_SCAN_IDLE = 2'd0,
        ID_SCAN_REQ  = 2'd1,
        ID_SCAN_GAP  = 2'd2,
        ID_SCAN_FIN  = 2'd3
    } scan_state_e;

    localparam int ID_SCAN_TIMEOUT_DEF = 16;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/id_scan_timer.sv
// REQ wait counter; only instantiated when ID_SCAN_TIMEOUT_EN is defined.
// expired is high during the TIMEOUT_CYC-th consecutive enabled cycle.
module id_scan_timer
    import id_scanner_pkg::*;
#(
    parameter int TIMEOUT_CYC = ID_SCAN_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = enable && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/id_scanner.sv
// Boot-time bus initiator: reads one ID register per slot, records IDs and
// which slots answered. Optional absent-slot timeout under ID_SCAN_TIMEOUT_EN.
module id_scanner
    import id_scanner_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                N_SLOTS     = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                STRIDE      = 4,
    parameter int                TIMEOUT_CYC = ID_SCAN_TIMEOUT_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic [N_SLOTS-1:0]             present,
    input  logic [sel_width(N_SLOTS)-1:0]  id_sel,
    output logic [DATA_W-1:0]              id_data,
    output logic                           m_valid,
    output logic [ADDR_W-1:0]              m_address,
    output logic [DATA_W/8-1:0]            m_wstrb,
    input  logic [DATA_W-1:0]              m_rdata,
    input  logic                           m_ready
);
    localparam int SEL_W = sel_width(N_SLOTS);

    scan_state_e        state_q, state_d;
    logic [SEL_W-1:0]   slot_q, slot_d;
    logic [N_SLOTS-1:0] present_q, present_d;
    logic [DATA_W-1:0]  ids_q [N_SLOTS];
    logic [DATA_W-1:0]  ids_d [N_SLOTS];
    logic               tmr_clr, tmr_exp, last_slot;

    assign last_slot = (slot_q == SEL_W'(N_SLOTS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ID_SCAN_IDLE;
            slot_q    <= '0;
            present_q <= '0;
            for (int i = 0; i < N_SLOTS; i++) ids_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            present_q <= present_d;
            ids_q     <= ids_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        present_d = present_q;
        ids_d     = ids_q;
        tmr_clr   = 1'b0;
        case (state_q)
            ID_SCAN_IDLE: begin
                if (start) begin
                    slot_d    = '0;
                    present_d = '0;
                    for (int i = 0; i < N_SLOTS; i++) ids_d[i] = '0;
                    tmr_clr   = 1'b1;
                    state_d   = ID_SCAN_REQ;
                end
            end
            ID_SCAN_REQ: begin
                // A response arriving in the expiry cycle still counts.
                if (m_ready) begin
                    ids_d[slot_q]     = m_rdata;
                    present_d[slot_q] = 1'b1;
                    state_d           = ID_SCAN_GAP;
                end else if (tmr_exp) begin
                    ids_d[slot_q]     = '0;
                    present_d[slot_q] = 1'b0;
                    state_d           = ID_SCAN_GAP;
                end
            end
            ID_SCAN_GAP: begin
                // Swallows the responder's trailing registered ready.
                if (last_slot) begin
                    state_d = ID_SCAN_FIN;
                end else begin
                    slot_d  = slot_q + 1'b1;
                    tmr_clr = 1'b1;
                    state_d = ID_SCAN_REQ;
                end
            end
            ID_SCAN_FIN: state_d = ID_SCAN_IDLE;
            default:     state_d = ID_SCAN_IDLE;
        endcase
    end

`ifdef ID_SCAN_TIMEOUT_EN
    id_scan_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clr),
        .enable  (state_q == ID_SCAN_REQ),
        .expired (tmr_exp)
    );
`else
    logic unused_tmr;
    assign tmr_exp    = 1'b0;
    assign unused_tmr = ^{tmr_clr, 32'(TIMEOUT_CYC)};
`endif

    assign m_valid   = (state_q == ID_SCAN_REQ);
    assign busy      = (state_q == ID_SCAN_REQ) || (state_q == ID_SCAN_GAP);
    assign done      = (state_q == ID_SCAN_FIN);
    assign present   = present_q;
    assign m_wstrb   = '0;
    assign m_address = m_valid ? (BASE_ADDR + ADDR_W'(slot_q) * ADDR_W'(STRIDE)) : '0;
    assign id_data   = (int'(id_sel) < N_SLOTS) ? ids_q[id_sel] : '0;

endmodule

// File: tb/tb_id_scanner.sv
// Bench for id_scanner: directed sequences, table-checked results and random
// scans against a cycle-budget/address model of the scan protocol.
module tb_id_scanner;
    localparam int N = 4, DW = 32, AW = 32, STRIDE = 4, TMO = 16;
    localparam logic [AW-1:0] BASE = '0;

    logic          clk = 1'b0;
    logic          rst, start, busy, done, m_valid, m_ready;
    logic [N-1:0]  present;
    logic [1:0]    id_sel;
    logic [DW-1:0] id_data, m_rdata;
    logic [AW-1:0] m_address;
    logic [DW/8-1:0] m_wstrb;

    always #5 clk = ~clk;

    id_scanner #(.DATA_W(DW), .ADDR_W(AW), .N_SLOTS(N), .BASE_ADDR(BASE),
                 .STRIDE(STRIDE), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .present(present), .id_sel(id_sel), .id_data(id_data),
        .m_valid(m_valid), .m_address(m_address), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ready(m_ready)
    );

    // Responder: registered ready, raised dly[slot] cycles late; muted slots never answer.
    logic [DW-1:0] id_tbl [N];
    int  dly [N];
    bit  mute [N];
    int  wcnt, cur;
    int  total = 0, bad = 0;

    assign cur = int'((m_address - BASE) / STRIDE);

    always @(posedge clk) begin
        if (rst || !m_valid || cur >= N) begin
            wcnt <= 0; m_ready <= 1'b0; m_rdata <= '0;
        end else begin
            wcnt    <= wcnt + 1;
            m_ready <= !mute[cur] && (wcnt >= dly[cur]);
            m_rdata <= id_tbl[cur];
        end
    end

    typedef struct { logic [1:0] sel; logic [DW-1:0] exp; } vec_t;
    vec_t vt [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic set_cfg(input logic [DW-1:0] a, b, c, d);
        id_tbl[0] = a; id_tbl[1] = b; id_tbl[2] = c; id_tbl[3] = d;
        for (int i = 0; i < N; i++) begin dly[i] = 0; mute[i] = 1'b0; end
    endtask

    // Model: slot i holds valid for (dly+2) cycles, or TMO if muted; one gap
    // per slot; done one cycle after the last gap.
    task automatic do_scan(input string tag, input int mid_start);
        logic [AW-1:0]   q[$];
        logic [DW/8-1:0] ws;
        int exp_done, k, len;
        bit got;
        exp_done = N + 1;
        for (int i = 0; i < N; i++) begin
            len = mute[i] ? TMO : dly[i] + 2;
            exp_done += len;
            for (int j = 0; j < len; j++) q.push_back(BASE + AW'(i * STRIDE));
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; k = 1; got = 1'b0; ws = '0;
        chk({tag, "_clr_present"}, present, 0);
        chk({tag, "_clr_id"}, id_data, 0);
        while (!got && k < 1000) begin
            ws |= m_wstrb;
            if (m_valid) begin
                if (q.size() == 0) chk({tag, "_extra_valid"}, 1, 0);
                else chk($sformatf("%s_addr_c%0d", tag, k), m_address, q.pop_front());
            end
            if (done) got = 1'b1;
            else begin
                start = (k == mid_start);
                @(negedge clk);
                k++;
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, got, 1);
        chk({tag, "_done_cyc"}, k, exp_done);
        chk({tag, "_addr_left"}, q.size(), 0);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_wstrb"}, ws, 0);
    endtask

    task automatic check_results(input string tag);
        logic [N-1:0] ep;
        for (int i = 0; i < N; i++) ep[i] = !mute[i];
        @(negedge clk);
        chk({tag, "_present"}, present, ep);
        chk({tag, "_done_pulse"}, done, 0);
        for (int i = 0; i < N; i++) begin
            id_sel = 2'(i);
            #1;
            chk($sformatf("%s_id%0d", tag, i), id_data, mute[i] ? '0 : id_tbl[i]);
        end
    endtask

    task automatic apply_vec(input int lo, input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            id_sel = vt[i].sel;
            #1;
            chk($sformatf("%s_vec%0d", tag, i), id_data, vt[i].exp);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found, dseen;
        int k;
        vt[0] = '{2'd0, 32'h0};  vt[1] = '{2'd1, 32'h0};
        vt[2] = '{2'd2, 32'h0};  vt[3] = '{2'd3, 32'h0};
        vt[4] = '{2'd0, 32'hA0}; vt[5] = '{2'd1, 32'hB1};
        vt[6] = '{2'd2, 32'hC2}; vt[7] = '{2'd3, 32'hD3};

        rst = 1'b1; start = 1'b0; id_sel = '0;
        set_cfg(32'hA0, 32'hB1, 32'hC2, 32'hD3);
        repeat (3) @(negedge clk);
        chk("rst_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_present", present, 0);
        chk("rst_addr", m_address, 0);
        chk("rst_wstrb", m_wstrb, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_valid", m_valid, 0);
        chk("idle_busy", busy, 0);
        apply_vec(0, 3, "rst");

        @(negedge clk);
        do_scan("basic", 0);
        check_results("basic");
        apply_vec(4, 7, "basic");

        dly[1] = 5;
        @(negedge clk);
        do_scan("slow", 0);
        check_results("slow");

        dly[1] = 0;
        do_scan("mid", 5);
        check_results("mid");

        // Reset while slot 2 is being requested.
        set_cfg(32'h11, 32'h22, 32'h33, 32'h44);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; k = 0; found = 1'b0;
        while (!found && k < 100) begin
            if (m_valid && m_address == 32'd8) found = 1'b1;
            else begin @(negedge clk); k++; end
        end
        chk("rstmid_found", found, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_valid", m_valid, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_present", present, 0);
        chk("rstmid_done", done, 0);
        rst = 1'b0; dseen = 1'b0;
        repeat (20) begin @(negedge clk); dseen |= done; end
        chk("rstmid_no_done", dseen, 0);
        apply_vec(0, 3, "rstmid");

        // Back-to-back: start during FIN is dropped, start right after is taken.
        @(negedge clk);
        do_scan("b2b1", 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("fin_start_ignored", busy, 0);
        chk("fin_present_hold", present, 4'hF);
        set_cfg(32'h0, 32'hDEAD_BEEF, 32'h5A5A_0001, 32'h7);
        do_scan("b2b2", 0);
        check_results("b2b2");

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                id_tbl[i] = (r == 0 && i == 2) ? '0 : $urandom;
                dly[i]    = $urandom_range(0, 6);
                mute[i]   = 1'b0;
`ifdef ID_SCAN_TIMEOUT_EN
                mute[i]   = ($urandom_range(0, 3) == 0);
`endif
            end
            @(negedge clk);
            do_scan($sformatf("rnd%0d", r), $urandom_range(1, 10));
            check_results($sformatf("rnd%0d", r));
        end

`ifdef ID_SCAN_TIMEOUT_EN
        set_cfg(32'hA0, 32'hB1, 32'hC2, 32'hD3);
        mute[3] = 1'b1;
        @(negedge clk);
        do_scan("tmo", 0);
        check_results("tmo");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
